// File: rtl/line_mem_responder.sv
// Line-granular memory model for a cache refill/write-back port: a single-port word array
// behind a fixed wait latency, moving one 32-bit word per cycle.
`timescale 1ns/1ps

module line_mem_responder #(
  parameter int unsigned ByteOffsetBits  = 5,
  parameter int unsigned MemWordAddrBits = 10,
  parameter int unsigned LATENCY         = 2,
  localparam int unsigned NrWordsPerLine = (2 ** ByteOffsetBits) / 4,
  localparam int unsigned LineSize       = 32 * NrWordsPerLine
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic [31:0]         mem_addr_i,
  input  logic                mem_read_en_i,
  output logic                mem_read_valid_o,
  output logic [LineSize-1:0] mem_read_data_o,
  input  logic                mem_write_en_i,
  input  logic [LineSize-1:0] mem_write_data_i,
  output logic                mem_write_valid_o,
  output logic                busy_o
);

  localparam int unsigned WCNT     = $clog2(NrWordsPerLine);
  localparam int unsigned LCNT     = ($clog2(LATENCY + 1) > 1) ? $clog2(LATENCY + 1) : 1;
  localparam int unsigned LineBits = MemWordAddrBits - WCNT;
  localparam int unsigned Depth    = 2 ** MemWordAddrBits;
  localparam logic [LCNT-1:0] LatInit  = LCNT'(LATENCY);
  localparam logic [WCNT-1:0] LastWord = WCNT'(NrWordsPerLine - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StRdBurst,
    StRdLast,
    StWrBurst,
    StResp
  } state_e;

  state_e                       state;
  logic [LineBits-1:0]          line_addr;
  logic                         is_write;
  logic [LineSize-1:0]          wdata;
  logic [LineSize-1:0]          line_buf;
  logic [LineSize-1:0]          rdata_line;
  logic [LCNT-1:0]              lat_cnt;
  logic [WCNT-1:0]              word_cnt;
  logic [WCNT-1:0]              prev_word;
  logic [31:0]                  mem_rdata;
  logic                         read_valid;
  logic                         write_valid;
  logic                         busy;
  logic [MemWordAddrBits-1:0]   word_addr;
  logic [31:0]                  wr_word;
  logic                         unused_addr_bits;

  logic [31:0] mem [Depth];

  // Offset and high address bits are deliberately dropped, so lines alias modulo the array.
  assign unused_addr_bits = ^{mem_addr_i[31:ByteOffsetBits+LineBits],
                              mem_addr_i[ByteOffsetBits-1:0]};

  assign word_addr = {line_addr, word_cnt};
  assign prev_word = word_cnt - 1'b1;
  assign wr_word   = wdata[32*word_cnt +: 32];

  // Array contents survive reset, so the write port carries no reset.
  always_ff @(posedge clk_i) begin
    if (state == StWrBurst) begin
      mem[word_addr] <= wr_word;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= StIdle;
      line_addr   <= '0;
      is_write    <= 1'b0;
      wdata       <= '0;
      line_buf    <= '0;
      rdata_line  <= '0;
      lat_cnt     <= '0;
      word_cnt    <= '0;
      mem_rdata   <= '0;
      read_valid  <= 1'b0;
      write_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      read_valid  <= 1'b0;
      write_valid <= 1'b0;
      unique case (state)
        StIdle: begin
          if (mem_write_en_i || mem_read_en_i) begin
            is_write  <= mem_write_en_i;
            line_addr <= mem_addr_i[ByteOffsetBits +: LineBits];
            if (mem_write_en_i) begin
              wdata <= mem_write_data_i;
            end
            lat_cnt  <= LatInit;
            word_cnt <= '0;
            busy     <= 1'b1;
            if (LATENCY == 0) begin
              state <= mem_write_en_i ? StWrBurst : StRdBurst;
            end else begin
              state <= StWait;
            end
          end
        end
        StWait: begin
          lat_cnt <= lat_cnt - 1'b1;
          if (lat_cnt == LCNT'(1)) begin
            state <= is_write ? StWrBurst : StRdBurst;
          end
        end
        StWrBurst: begin
          word_cnt <= word_cnt + 1'b1;
          if (word_cnt == LastWord) begin
            state       <= StResp;
            write_valid <= 1'b1;
          end
        end
        StRdBurst: begin
          mem_rdata <= mem[word_addr];
          // The word issued last cycle is now on mem_rdata.
          if (word_cnt != '0) begin
            line_buf[32*prev_word +: 32] <= mem_rdata;
          end
          word_cnt <= word_cnt + 1'b1;
          if (word_cnt == LastWord) begin
            state <= StRdLast;
          end
        end
        StRdLast: begin
          line_buf[LineSize-1 -: 32] <= mem_rdata;
          rdata_line                 <= {mem_rdata, line_buf[LineSize-33:0]};
          read_valid                 <= 1'b1;
          state                      <= StResp;
        end
        StResp: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

  assign mem_read_valid_o  = read_valid;
  assign mem_write_valid_o = write_valid;
  assign mem_read_data_o   = rdata_line;
  assign busy_o            = busy;

endmodule

// File: tb/tb_line_mem_responder.sv
// Randomised scoreboard bench for line_mem_responder: a line-level memory model predicts every
// response; a negedge monitor pops and checks kind, latency and data.
`timescale 1ns/1ps

module tb_line_mem_responder;

  localparam int unsigned BOB    = 5;
  localparam int unsigned MWB    = 10;
  localparam int unsigned LAT    = 2;
  localparam int unsigned N      = (2 ** BOB) / 4;
  localparam int unsigned LS     = 32 * N;
  localparam int unsigned NLines = (2 ** MWB) / N;

  typedef struct packed {
    logic          wr;
    logic [LS-1:0] data;
    int            acc;
  } exp_t;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          rstn_i;
  logic [31:0]   mem_addr_i;
  logic          mem_read_en_i;
  logic          mem_read_valid_o;
  logic [LS-1:0] mem_read_data_o;
  logic          mem_write_en_i;
  logic [LS-1:0] mem_write_data_i;
  logic          mem_write_valid_o;
  logic          busy_o;

  logic          z_rstn;
  logic [31:0]   z_addr;
  logic          z_re;
  logic          z_rv;
  logic [LS-1:0] z_rdata;
  logic          z_we;
  logic [LS-1:0] z_wdata;
  logic          z_wv;
  logic          z_busy;

  line_mem_responder #(.ByteOffsetBits(BOB), .MemWordAddrBits(MWB), .LATENCY(LAT)) dut (
    .clk_i            (clk_i),
    .rstn_i           (rstn_i),
    .mem_addr_i       (mem_addr_i),
    .mem_read_en_i    (mem_read_en_i),
    .mem_read_valid_o (mem_read_valid_o),
    .mem_read_data_o  (mem_read_data_o),
    .mem_write_en_i   (mem_write_en_i),
    .mem_write_data_i (mem_write_data_i),
    .mem_write_valid_o(mem_write_valid_o),
    .busy_o           (busy_o)
  );

  line_mem_responder #(.ByteOffsetBits(BOB), .MemWordAddrBits(MWB), .LATENCY(0)) dut0 (
    .clk_i            (clk_i),
    .rstn_i           (z_rstn),
    .mem_addr_i       (z_addr),
    .mem_read_en_i    (z_re),
    .mem_read_valid_o (z_rv),
    .mem_read_data_o  (z_rdata),
    .mem_write_en_i   (z_we),
    .mem_write_data_i (z_wdata),
    .mem_write_valid_o(z_wv),
    .busy_o           (z_busy)
  );

  int            cyc = 0;
  int            errors = 0;
  int            checks = 0;
  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [LS-1:0] last_line = '0;
  logic [LS-1:0] model [NLines];

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_line(input string name, input logic [LS-1:0] act, input logic [LS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [LS-1:0] rand_line();
    logic [LS-1:0] l;
    for (int k = 0; k < N; k++) l[32*k +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [LS-1:0] pattern_line();
    logic [LS-1:0] l;
    for (int k = 0; k < N; k++) l[32*k +: 32] = 32'hA5A5_0000 + k;
    return l;
  endfunction

  // Random offset and random high bits around a chosen line index.
  function automatic logic [31:0] mk_addr(input int l);
    return ($urandom & ~(32'(NLines - 1) << BOB)) | (32'(l) << BOB);
  endfunction

  function automatic int line_of(input logic [31:0] a);
    return int'((a >> BOB) % NLines);
  endfunction

  // Monitor: every valid must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (mem_read_valid_o && mem_write_valid_o) begin
      checks++;
      errors++;
      $display("FAIL dual_valid: both valids high at cycle %0d", cyc);
    end else if (mem_read_valid_o || mem_write_valid_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: read=%0b write=%0b with nothing outstanding (cycle %0d)",
                 mem_read_valid_o, mem_write_valid_o, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check_int("valid_kind_is_write", int'(mem_write_valid_o), int'(mon_e.wr));
        check_int("latency", cyc + 1 - mon_e.acc, mon_e.wr ? LAT + N + 1 : LAT + N + 2);
        if (!mon_e.wr) begin
          check_line("read_data", mem_read_data_o, mon_e.data);
          last_line = mon_e.data;
        end
      end
    end else begin
      check_line("read_data_hold", mem_read_data_o, last_line);
    end
  end

  task automatic scramble();
    mem_write_en_i   = 1'($urandom_range(0, 1));
    mem_read_en_i    = 1'($urandom_range(0, 1));
    mem_addr_i       = $urandom;
    mem_write_data_i = rand_line();
  endtask

  task automatic idle(input int n);
    mem_write_en_i   = 1'b0;
    mem_read_en_i    = 1'b0;
    mem_addr_i       = $urandom;
    mem_write_data_i = rand_line();
    repeat (n) @(negedge clk_i);
  endtask

  // Pushes the expectation and waits until the valid is seen (returns on that RESP negedge).
  task automatic run(input logic wr, input logic [31:0] addr, input logic [LS-1:0] data,
                     input int acc, input logic mess);
    exp_t e;
    int   bc;
    logic seen;
    e.wr  = wr;
    e.acc = acc;
    if (wr) begin
      model[line_of(addr)] = data;
      e.data = data;
    end else begin
      e.data = model[line_of(addr)];
    end
    exp_q.push_back(e);
    bc   = 0;
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk_i);
      if (busy_o) bc++;
      if (wr ? mem_write_valid_o : mem_read_valid_o) seen = 1'b1;
      else if (mess && cyc >= acc) scramble();
    end
    check_int("valid_seen", int'(seen), 1);
    check_int("busy_cycles", bc, wr ? LAT + N + 1 : LAT + N + 2);
  endtask

  // b2b: called on the previous RESP negedge, so acceptance follows one IDLE cycle later.
  task automatic txn(input logic wr, input logic [31:0] addr, input logic [LS-1:0] data,
                     input logic b2b, input logic mess);
    int acc;
    mem_write_en_i   = wr;
    mem_read_en_i    = !wr;
    mem_addr_i       = addr;
    mem_write_data_i = wr ? data : rand_line();
    acc = cyc + (b2b ? 2 : 1);
    run(wr, addr, data, acc, mess);
  endtask

  task automatic lat0_seq();
    int            acc;
    int            bc;
    logic          seen;
    logic          stray;
    logic [LS-1:0] d;
    d       = pattern_line();
    z_rstn  = 1'b0;
    z_we    = 1'b0;
    z_re    = 1'b0;
    z_addr  = '0;
    z_wdata = '0;
    repeat (2) @(negedge clk_i);
    z_rstn  = 1'b1;
    z_we    = 1'b1;
    z_addr  = 32'h40;
    z_wdata = d;
    acc     = cyc + 1;
    bc = 0; seen = 1'b0; stray = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk_i);
      if (z_busy) bc++;
      if (z_rv) stray = 1'b1;
      if (z_wv) seen = 1'b1;
    end
    check_int("l0_write_seen", int'(seen), 1);
    check_int("l0_write_latency", cyc + 1 - acc, N + 1);
    check_int("l0_write_busy_cycles", bc, N + 1);
    check_int("l0_no_read_valid_on_write", int'(stray), 0);
    z_we = 1'b0;
    z_re = 1'b1;
    acc  = cyc + 2;
    bc = 0; seen = 1'b0; stray = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk_i);
      if (z_busy) bc++;
      if (z_wv) stray = 1'b1;
      if (z_rv) seen = 1'b1;
    end
    check_int("l0_read_seen", int'(seen), 1);
    check_int("l0_read_latency", cyc + 1 - acc, N + 2);
    check_int("l0_read_busy_cycles", bc, N + 2);
    check_int("l0_no_write_valid_on_read", int'(stray), 0);
    check_line("l0_read_data", z_rdata, d);
    z_re = 1'b0;
    @(negedge clk_i);
    check_int("l0_busy_after_resp", int'(z_busy), 0);
    check_line("l0_read_data_hold", z_rdata, d);
  endtask

  task automatic main_seq();
    logic [LS-1:0] d;
    logic [LS-1:0] old_d;
    int            acc;
    int            l;
    logic          wr;
    logic          b2b;
    logic          mess;

    rstn_i           = 1'b0;
    mem_write_en_i   = 1'b0;
    mem_read_en_i    = 1'b0;
    mem_addr_i       = '0;
    mem_write_data_i = '0;
    #1;
    check_int("reset_busy", int'(busy_o), 0);
    check_int("reset_read_valid", int'(mem_read_valid_o), 0);
    check_int("reset_write_valid", int'(mem_write_valid_o), 0);
    check_line("reset_read_data", mem_read_data_o, '0);
    repeat (2) @(negedge clk_i);

    // First request rides in on reset release; pattern write then read-back.
    rstn_i = 1'b1;
    txn(1'b1, 32'h40, pattern_line(), 1'b0, 1'b0);
    idle(1);
    txn(1'b0, 32'h40, '0, 1'b0, 1'b0);
    check_line("pattern_readback", mem_read_data_o, pattern_line());

    for (int i = 0; i < 8; i++) txn(1'b1, mk_addr(i), rand_line(), 1'b1, 1'b0);

    // Aliasing across the array size.
    d = rand_line();
    txn(1'b1, 32'h20, d, 1'b1, 1'b0);
    idle(2);
    txn(1'b0, 32'h20 + (32'h1 << (MWB + 2)), '0, 1'b0, 1'b0);
    check_line("alias_line", mem_read_data_o, d);

    // Both enables together: write wins, read then sees the new data.
    idle(1);
    d = rand_line();
    mem_write_en_i   = 1'b1;
    mem_read_en_i    = 1'b1;
    mem_addr_i       = 32'h40;
    mem_write_data_i = d;
    run(1'b1, 32'h40, d, cyc + 1, 1'b0);
    mem_write_en_i = 1'b0;
    run(1'b0, 32'h40, '0, cyc + 2, 1'b0);
    check_line("both_en_read_new", mem_read_data_o, d);

    // Write-back of A released on valid, read of B right behind it.
    idle(1);
    txn(1'b1, mk_addr(3), rand_line(), 1'b0, 1'b0);
    txn(1'b0, mk_addr(5), '0, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      wr   = 1'($urandom_range(0, 1));
      b2b  = 1'($urandom_range(0, 1));
      mess = 1'($urandom_range(0, 1));
      l    = int'($urandom_range(0, 7));
      if (!b2b) idle(int'($urandom_range(1, 3)));
      txn(wr, mk_addr(l), rand_line(), b2b, mess);
    end

    // Reset while word 3 of a write burst is pending.
    old_d = rand_line();
    txn(1'b1, mk_addr(4), old_d, 1'b1, 1'b0);
    idle(1);
    d = rand_line();
    mem_write_en_i   = 1'b1;
    mem_read_en_i    = 1'b0;
    mem_addr_i       = mk_addr(4);
    mem_write_data_i = d;
    acc = cyc + 1;
    for (int n = 0; n < 50 && cyc < acc + LAT + 3; n++) @(negedge clk_i);
    check_int("reached_word3", cyc, acc + LAT + 3);
    #2;
    rstn_i    = 1'b0;
    last_line = '0;
    #1;
    check_int("midburst_reset_busy", int'(busy_o), 0);
    check_int("midburst_reset_write_valid", int'(mem_write_valid_o), 0);
    check_int("midburst_reset_read_valid", int'(mem_read_valid_o), 0);
    check_line("midburst_reset_read_data", mem_read_data_o, '0);
    for (int k = 0; k < 3; k++) old_d[32*k +: 32] = d[32*k +: 32];
    model[4] = old_d;
    @(negedge clk_i);
    mem_write_en_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;
    txn(1'b0, mk_addr(4), '0, 1'b0, 1'b0);
    check_line("partial_line_after_reset", mem_read_data_o, old_d);

    idle(4);
    check_int("outstanding_after_run", exp_q.size(), 0);
  endtask

  initial begin
    fork
      main_seq();
      lat0_seq();
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
